// File: rtl/pgm_sdram_arbiter.sv
// Shares one SDRAM controller port between the ROM download writer, 68k program reads
// and graphics reads; one transaction outstanding at a time, download words buffered one deep.
module pgm_sdram_arbiter #(
    parameter int              ADDR_W    = 24,
    parameter logic [7:0]      DL_INDEX  = 8'd0,
    parameter logic [ADDR_W-1:0] DL_BASE = '0,
    parameter int              CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [15:0]       cpu_dout,
    input  logic              gfx_req,
    input  logic [ADDR_W-1:0] gfx_addr,
    output logic              gfx_ack,
    output logic [15:0]       gfx_dout,
    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_din,
    input  logic              sd_ack,
    input  logic [15:0]       sd_dout,
    output logic              dl_overflow
);

    localparam int STREAK_W = $clog2(CPU_BURST + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_GFX} owner_t;

    state_t              state;
    owner_t              owner;
    logic                dl_valid;
    logic [ADDR_W-1:0]   dl_addr;
    logic [15:0]         dl_data;
    logic [STREAK_W-1:0] streak;

    logic              capture;
    logic              drain;
    logic              gfx_forced;
    logic              grant_dl;
    logic              grant_cpu;
    logic              grant_gfx;
    logic [ADDR_W-1:0] cap_addr;
    logic              unused_addr_bits;

    // Byte address bit 0 and bits above the word range never reach the SDRAM.
    assign unused_addr_bits = ^{ioctl_addr[26:ADDR_W+1], ioctl_addr[0]};

    always_comb begin
        capture    = ioctl_wr && ioctl_download && (ioctl_index == DL_INDEX);
        drain      = (state == DONE) && (owner == OWN_DL);
        cap_addr   = DL_BASE + ioctl_addr[ADDR_W:1];
        gfx_forced = gfx_req && (streak == STREAK_W'(CPU_BURST));
        grant_dl   = (state == IDLE) && dl_valid;
        grant_cpu  = (state == IDLE) && !dl_valid && !ioctl_download
                     && cpu_req && !gfx_forced;
        grant_gfx  = (state == IDLE) && !dl_valid && !ioctl_download
                     && gfx_req && (gfx_forced || !cpu_req);
    end

    assign ioctl_wait = dl_valid;

    // A drain in the same cycle frees the slot, so the incoming word is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_valid    <= 1'b0;
            dl_addr     <= '0;
            dl_data     <= '0;
            dl_overflow <= 1'b0;
        end else if (capture && (!dl_valid || drain)) begin
            dl_valid <= 1'b1;
            dl_addr  <= cap_addr;
            dl_data  <= ioctl_dout;
        end else begin
            if (capture) dl_overflow <= 1'b1;
            if (drain)   dl_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= OWN_DL;
            streak   <= '0;
            sd_req   <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= '0;
            sd_din   <= '0;
            cpu_ack  <= 1'b0;
            gfx_ack  <= 1'b0;
            cpu_dout <= '0;
            gfx_dout <= '0;
        end else begin
            cpu_ack <= 1'b0;
            gfx_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!gfx_req || grant_gfx) streak <= '0;
                    else if (grant_cpu)        streak <= streak + 1'b1;

                    if (grant_dl) begin
                        owner   <= OWN_DL;
                        sd_we   <= 1'b1;
                        sd_addr <= dl_addr;
                        sd_din  <= dl_data;
                        sd_req  <= 1'b1;
                        state   <= BUSY;
                    end else if (grant_cpu) begin
                        owner   <= OWN_CPU;
                        sd_we   <= 1'b0;
                        sd_addr <= cpu_addr;
                        sd_req  <= 1'b1;
                        state   <= BUSY;
                    end else if (grant_gfx) begin
                        owner   <= OWN_GFX;
                        sd_we   <= 1'b0;
                        sd_addr <= gfx_addr;
                        sd_req  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Ack is registered here so it is high exactly during DONE.
                    if (sd_ack) begin
                        sd_req <= 1'b0;
                        state  <= DONE;
                        case (owner)
                            OWN_CPU: begin
                                cpu_dout <= sd_dout;
                                cpu_ack  <= 1'b1;
                            end
                            OWN_GFX: begin
                                gfx_dout <= sd_dout;
                                gfx_ack  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_sdram_arbiter.sv
// Directed and randomized checks of pgm_sdram_arbiter against an SDRAM responder
// and a word-level memory/ordering model.
module tb_pgm_sdram_arbiter;

    localparam logic [23:0] BASE = 24'h100000;

    logic        clk = 1'b0;
    logic        reset, ioctl_download, ioctl_wr, ioctl_wait;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        cpu_req, cpu_ack, gfx_req, gfx_ack;
    logic [23:0] cpu_addr, gfx_addr;
    logic [15:0] cpu_dout, gfx_dout;
    logic        sd_req, sd_we, sd_ack, dl_overflow;
    logic [23:0] sd_addr;
    logic [15:0] sd_din, sd_dout;

    always #5 clk = ~clk;

    pgm_sdram_arbiter #(
        .ADDR_W(24), .DL_INDEX(8'd0), .DL_BASE(24'h100000), .CPU_BURST(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack), .gfx_dout(gfx_dout),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_ack(sd_ack), .sd_dout(sd_dout), .dl_overflow(dl_overflow)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [23:0] addr; logic [15:0] din; } txn_t;
    txn_t        txn_q[$];
    logic [15:0] sdram   [logic [23:0]];
    logic [15:0] ref_mem [logic [23:0]];
    bit          resp_en      = 1'b1;
    int          resp_delay   = 2;
    int          last_ack_cyc = -1;

    function automatic logic [15:0] init_word(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], 8'h3C};
    endfunction

    function automatic logic [15:0] expect_word(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [23:0] dl_word(input logic [26:0] ba);
        logic [31:0] s;
        s = 32'(BASE) + 32'(ba >> 1);
        return s[23:0];
    endfunction

    // SDRAM controller model: acks resp_delay cycles into a request.
    initial begin : responder
        int   age;
        txn_t t;
        age = 0; sd_ack = 1'b0; sd_dout = '0;
        forever begin
            @(posedge clk); #1;
            sd_ack = 1'b0;
            if (!sd_req) age = 0;
            else if (resp_en) begin
                age++;
                if (age >= resp_delay) begin
                    age = 0;
                    t.we = sd_we; t.addr = sd_addr; t.din = sd_din;
                    txn_q.push_back(t);
                    if (sd_we) sdram[sd_addr] = sd_din;
                    else sd_dout = sdram.exists(sd_addr) ? sdram[sd_addr] : init_word(sd_addr);
                    sd_ack = 1'b1;
                    last_ack_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input logic we, input logic [23:0] addr,
                           input logic [15:0] din, input int n);
        txn_t t;
        chk({tag, "_count"}, txn_q.size(), n);
        if (txn_q.size() > 0) begin
            t = txn_q.pop_front();
            chk({tag, "_we"}, t.we, we);
            chk({tag, "_addr"}, t.addr, addr);
            if (we) chk({tag, "_din"}, t.din, din);
        end
    endtask

    task automatic do_read(input bit is_gfx, input logic [23:0] a, output logic [15:0] d,
                           output int issue_c, output int grant_c, output int ack_c);
        grant_c = -1; ack_c = -1; issue_c = cyc;
        if (is_gfx) begin gfx_addr = a; gfx_req = 1'b1; end
        else        begin cpu_addr = a; cpu_req = 1'b1; end
        for (int n = 0; n < 200; n++) begin
            tick();
            if (sd_req && grant_c < 0) grant_c = cyc;
            if (is_gfx ? gfx_ack : cpu_ack) begin ack_c = cyc; break; end
        end
        d = is_gfx ? gfx_dout : cpu_dout;
        if (is_gfx) gfx_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic read_check(input string tag, input bit is_gfx, input logic [23:0] a);
        logic [15:0] d;
        int ic, gc, ac;
        do_read(is_gfx, a, d, ic, gc, ac);
        chk({tag, "_acked"}, 32'(ac >= 0), 1);
        chk({tag, "_dout"}, d, expect_word(a));
        chk_txn(tag, 1'b0, a, '0, 1);
    endtask

    task automatic dual_read(input string tag, input logic [23:0] ca, input logic [23:0] ga);
        int nacks;
        nacks = 0;
        cpu_addr = ca; gfx_addr = ga; cpu_req = 1'b1; gfx_req = 1'b1;
        for (int n = 0; n < 300 && (cpu_req || gfx_req); n++) begin
            tick();
            if (cpu_ack) begin
                chk({tag, "_cpu_dout"}, cpu_dout, expect_word(ca));
                chk({tag, "_cpu_first"}, nacks, 0);
                nacks++; cpu_req = 1'b0;
            end
            if (gfx_ack) begin
                chk({tag, "_gfx_dout"}, gfx_dout, expect_word(ga));
                chk({tag, "_gfx_second"}, nacks, 1);
                nacks++; gfx_req = 1'b0;
            end
        end
        cpu_req = 1'b0; gfx_req = 1'b0;
        chk({tag, "_both"}, nacks, 2);
        chk_txn({tag, "_c"}, 1'b0, ca, '0, 2);
        chk_txn({tag, "_g"}, 1'b0, ga, '0, 1);
    endtask

    task automatic dl_write(input logic [26:0] ba, input logic [15:0] d);
        ioctl_addr = ba; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (ioctl_wait && n < 200) begin tick(); n++; end
        chk(tag, ioctl_wait, 0);
    endtask

    initial begin : main
        logic [15:0] d, wd;
        logic [26:0] ba;
        int ic, gc, ac, hits, got, n, op;

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; cpu_req = 1'b0; cpu_addr = '0;
        gfx_req = 1'b0; gfx_addr = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: reset state and idle
        chk("reset_flags", {ioctl_wait, cpu_ack, gfx_ack, sd_req, sd_we, dl_overflow}, 0);
        chk("reset_cpu_dout", cpu_dout, 0);
        chk("reset_gfx_dout", gfx_dout, 0);
        chk("reset_sd_addr", sd_addr, 0);
        chk("reset_sd_din", sd_din, 0);
        hits = 0;
        repeat (8) begin tick(); if (sd_req) hits++; end
        chk("idle_no_req", hits, 0);

        // 2: single cpu read with 5-cycle SDRAM latency
        sdram[24'h000100]   = 16'hBEEF;
        ref_mem[24'h000100] = 16'hBEEF;
        resp_delay = 5;
        do_read(1'b0, 24'h000100, d, ic, gc, ac);
        chk("t2_grant_lat", gc - ic, 1);
        chk("t2_ack_lat", ac - last_ack_cyc, 1);
        chk("t2_dout", d, 16'hBEEF);
        chk_txn("t2", 1'b0, 24'h000100, '0, 1);
        tick();
        chk("t2_ack_pulse", cpu_ack, 0);
        chk("t2_dout_hold", cpu_dout, 16'hBEEF);

        // 3: download write
        resp_delay = 3;
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        dl_write(27'h10, 16'h1234);
        chk("t3_wait_set", ioctl_wait, 1);
        tick();
        chk("t3_sd_req", sd_req, 1);
        chk("t3_sd_we", sd_we, 1);
        chk("t3_sd_addr", sd_addr, 24'h100008);
        chk("t3_sd_din", sd_din, 16'h1234);
        wait_drain("t3_wait_clear");
        chk_txn("t3", 1'b1, 24'h100008, 16'h1234, 1);
        ref_mem[24'h100008] = 16'h1234;

        dl_write(27'h7FFFFFF, 16'hC0DE);
        wait_drain("wrap_drain");
        chk_txn("wrap", 1'b1, dl_word(27'h7FFFFFF), 16'hC0DE, 1);
        ref_mem[dl_word(27'h7FFFFFF)] = 16'hC0DE;

        ioctl_index = 8'd3;
        dl_write(27'h20, 16'hDEAD);
        tick();
        chk("idx_no_capture", {ioctl_wait, sd_req}, 0);
        ioctl_index = 8'd0;

        // new word arriving in the very cycle the previous one drains
        dl_write(27'h40, 16'h1111);
        n = 0;
        while (!sd_req && n < 50) begin tick(); n++; end
        while (sd_req && n < 50) begin tick(); n++; end
        dl_write(27'h42, 16'h2222);
        chk("same_cyc_wait", ioctl_wait, 1);
        chk("same_cyc_no_ovf", dl_overflow, 0);
        wait_drain("same_cyc_drain");
        chk_txn("same_cyc_a", 1'b1, dl_word(27'h40), 16'h1111, 2);
        chk_txn("same_cyc_b", 1'b1, dl_word(27'h42), 16'h2222, 1);
        ref_mem[dl_word(27'h40)] = 16'h1111;
        ref_mem[dl_word(27'h42)] = 16'h2222;

        // reads are held off while download is active
        cpu_addr = 24'h100008; cpu_req = 1'b1;
        hits = 0;
        repeat (10) begin tick(); if (sd_req || cpu_ack) hits++; end
        chk("dl_blocks_rd", hits, 0);
        ioctl_download = 1'b0;
        read_check("after_dl", 1'b0, 24'h100008);
        tick();

        // 4: cpu burst limit with both requests held
        resp_delay = 1;
        cpu_addr = 24'h100003; gfx_addr = 24'h100005;
        cpu_req = 1'b1; gfx_req = 1'b1;
        got = 0;
        for (int i = 0; i < 400 && got < 10; i++) begin
            tick();
            if (cpu_ack || gfx_ack) begin
                chk($sformatf("burst_who%0d", got), gfx_ack, 32'(got % 5 == 4));
                chk($sformatf("burst_dout%0d", got), gfx_ack ? gfx_dout : cpu_dout,
                    gfx_ack ? expect_word(24'h100005) : expect_word(24'h100003));
                got++;
            end
        end
        cpu_req = 1'b0; gfx_req = 1'b0;
        chk("burst_count", got, 10);
        txn_q.delete();
        tick();

        // 5: overflow while buffer full and undrained
        chk("ovf_clear", dl_overflow, 0);
        resp_en = 1'b0; ioctl_download = 1'b1;
        dl_write(27'h60, 16'hAAAA);
        tick(); tick();
        dl_write(27'h62, 16'h5555);
        tick();
        chk("ovf_set", dl_overflow, 1);
        chk("ovf_wait", ioctl_wait, 1);
        resp_en = 1'b1;
        wait_drain("ovf_drain");
        chk_txn("ovf_first", 1'b1, dl_word(27'h60), 16'hAAAA, 1);
        ref_mem[dl_word(27'h60)] = 16'hAAAA;
        ioctl_download = 1'b0;
        read_check("ovf_absent", 1'b0, dl_word(27'h62));
        chk("ovf_sticky", dl_overflow, 1);
        tick();

        // 6: reset while a read is in flight
        resp_en = 1'b0; cpu_addr = 24'h100010; cpu_req = 1'b1;
        n = 0;
        while (!sd_req && n < 50) begin tick(); n++; end
        chk("rst_busy_req", sd_req, 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_drop", {sd_req, cpu_ack, gfx_ack, dl_overflow, ioctl_wait}, 0);
        cpu_req = 1'b0; reset = 1'b0; resp_en = 1'b1;
        hits = 0;
        repeat (6) begin tick(); if (cpu_ack || gfx_ack || sd_req) hits++; end
        chk("rst_no_ack", hits, 0);
        read_check("rst_after", 1'b0, 24'h100010);
        tick();

        // randomized mix
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            resp_delay = $urandom_range(1, 6);
            case (op)
                0: read_check($sformatf("rnd%0d_cpu", it), 1'b0, BASE + 24'($urandom_range(0, 31)));
                1: read_check($sformatf("rnd%0d_gfx", it), 1'b1, BASE + 24'($urandom_range(0, 31)));
                2: begin
                    ba = 27'($urandom_range(0, 63));
                    wd = 16'($urandom);
                    ioctl_download = 1'b1;
                    dl_write(ba, wd);
                    wait_drain($sformatf("rnd%0d_drain", it));
                    ioctl_download = 1'b0;
                    chk_txn($sformatf("rnd%0d_dl", it), 1'b1, dl_word(ba), wd, 1);
                    ref_mem[dl_word(ba)] = wd;
                end
                default: dual_read($sformatf("rnd%0d_dual", it),
                                   BASE + 24'($urandom_range(0, 31)),
                                   BASE + 24'($urandom_range(0, 31)));
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
